// File: rtl/deser_pkg.sv
// Shared types and sizing helpers for the serial-link deserializer.
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Number of serial chunks that make up one assembled word.
  function automatic int unsigned chunks(input int unsigned inwidth, input int unsigned outwidth);
    return inwidth / outwidth;
  endfunction

  // Frame-length port width for the default 256/8 link, shared with the serializer.
  localparam int unsigned COUNT_W = $clog2(chunks(256, 8)) + 1;

endpackage

// File: rtl/deserializer.sv
// Reassembles LSB-first serial chunks into one wide word and presents it
// to the core with a valid/ready handshake.
module deserializer
  import deser_pkg::*;
#(
  parameter int unsigned INWIDTH  = 256,
  parameter int unsigned OUTWIDTH = 8,
  localparam int unsigned CHUNKS  = chunks(INWIDTH, OUTWIDTH),
  localparam int unsigned CW      = $clog2(CHUNKS) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CW-1:0]       length,
  input  logic [OUTWIDTH-1:0] serial_in,
  input  logic                serial_valid,
  output logic [INWIDTH-1:0]  out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned IW = CW - 1;

  state_t               state, state_n;
  logic [INWIDTH-1:0]   out_n;
  logic                 out_valid_n;
  logic                 busy_n;
  logic                 overrun_n;
  logic [IW-1:0]        index, index_n;
  logic [CW-1:0]        remaining, remaining_n;
  logic                 launch;

  // State and datapath registers; reset discards any partial word at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      index     <= '0;
      remaining <= '0;
    end else begin
      state     <= state_n;
      out       <= out_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
      overrun   <= overrun_n;
      index     <= index_n;
      remaining <= remaining_n;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n     = state;
    out_n       = out;
    out_valid_n = out_valid;
    overrun_n   = overrun;
    index_n     = index;
    remaining_n = remaining;
    launch      = 1'b0;

    case (state)
      IDLE: begin
        launch = start && (length != '0);
      end

      COLLECT: begin
        if (serial_valid) begin
          for (int i = 0; i < int'(CHUNKS); i++) begin
            if (index == IW'(i)) begin
              out_n[i*OUTWIDTH +: OUTWIDTH] = serial_in;
            end
          end
          remaining_n = remaining - 1'b1;
          // Index wraps to zero on the last chunk so it never passes CHUNKS-1.
          if (remaining == CW'(1)) begin
            state_n     = HOLD;
            out_valid_n = 1'b1;
            index_n     = '0;
          end else begin
            index_n = index + 1'b1;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
          launch      = start && (length != '0);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (launch) begin
      state_n     = COLLECT;
      remaining_n = (length > CW'(CHUNKS)) ? CW'(CHUNKS) : length;
      out_n       = '0;
      index_n     = '0;
      overrun_n   = 1'b0;
    end

    // A chunk arriving while the word is parked is lost; flag it.
    if ((state == HOLD) && serial_valid) begin
      overrun_n = 1'b1;
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for the deserializer.
module tb_deserializer;

  localparam int unsigned CW = 6;

  logic           clk;
  logic           reset;
  logic           start;
  logic [CW-1:0]  length;
  logic [7:0]     serial_in;
  logic           serial_valid;
  logic [255:0]   out;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
  logic           overrun;

  int n_checks;
  int n_fail;

  deserializer #(.INWIDTH(256), .OUTWIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .length       (length),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .out          (out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; length = '0; serial_in = '0;
    serial_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_checks++; if (out !== 256'd0) begin n_fail++; $display("FAIL reset_out got %h exp 0", out); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] c [4];
    c[0] = 8'h11; c[1] = 8'h22; c[2] = 8'h33; c[3] = 8'h44;
    start = 1'b1; length = 6'd4;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b exp 1", busy); end
    for (int i = 0; i < 4; i++) begin
      serial_valid = 1'b1; serial_in = c[i];
      tick();
      if (i == 2) begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b exp 0", out_valid); end
      end
    end
    serial_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    n_checks++; if (out[31:0] !== 32'h44332211) begin n_fail++; $display("FAIL basic_low got %h exp 44332211", out[31:0]); end
    n_checks++; if (out[255:32] !== 224'd0) begin n_fail++; $display("FAIL basic_upper got %h exp 0", out[255:32]); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun got %b exp 0", overrun); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_accept_valid got %b exp 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_accept_busy got %b exp 0", busy); end
  endtask

  task automatic test_idle_noise();
    serial_valid = 1'b1; serial_in = 8'hFF;
    tick();
    serial_valid = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL idle_overrun got %b exp 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_gaps();
    logic [255:0] exp;
    for (int i = 0; i < 32; i++) exp[i*8 +: 8] = 8'(i);
    start = 1'b1; length = 6'd32;
    tick();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      serial_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      serial_valid = 1'b1; serial_in = 8'(i);
      tick();
    end
    serial_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_valid got %b exp 1", out_valid); end
    n_checks++; if (out !== exp) begin n_fail++; $display("FAIL gaps_word got %h exp %h", out, exp); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_hold_valid cycle %0d got %b exp 1", k, out_valid); end
      n_checks++; if (out !== exp) begin n_fail++; $display("FAIL gaps_hold_word cycle %0d got %h exp %h", k, out, exp); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_accept got %b exp 0", out_valid); end
  endtask

  // Leaves the DUT in HOLD with overrun set for the back-to-back test.
  task automatic test_clamp();
    logic [255:0] exp;
    for (int i = 0; i < 32; i++) exp[i*8 +: 8] = 8'(8'h80 + i);
    start = 1'b1; length = 6'd40;
    tick();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      serial_valid = 1'b1; serial_in = 8'(8'h80 + i);
      tick();
    end
    serial_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clamp_valid got %b exp 1", out_valid); end
    n_checks++; if (out !== exp) begin n_fail++; $display("FAIL clamp_word got %h exp %h", out, exp); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL clamp_no_overrun got %b exp 0", overrun); end
    serial_valid = 1'b1; serial_in = 8'hEE;
    tick();
    serial_valid = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL clamp_overrun got %b exp 1", overrun); end
    n_checks++; if (out !== exp) begin n_fail++; $display("FAIL clamp_word_kept got %h exp %h", out, exp); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clamp_valid_kept got %b exp 1", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; start = 1'b1; length = 6'd2;
    tick();
    out_ready = 1'b0; start = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid got %b exp 0", out_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b exp 1", busy); end
    n_checks++; if (out !== 256'd0) begin n_fail++; $display("FAIL b2b_cleared got %h exp 0", out); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun_clear got %b exp 0", overrun); end
    serial_valid = 1'b1; serial_in = 8'hAA;
    tick();
    serial_in = 8'hBB;
    tick();
    serial_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b exp 1", out_valid); end
    n_checks++; if (out[15:0] !== 16'hBBAA) begin n_fail++; $display("FAIL b2b_low got %h exp bbaa", out[15:0]); end
    n_checks++; if (out[255:16] !== 240'd0) begin n_fail++; $display("FAIL b2b_upper got %h exp 0", out[255:16]); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; length = 6'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      serial_valid = 1'b1; serial_in = 8'(8'h51 + i);
      tick();
    end
    serial_valid = 1'b0;
    n_checks++; if (out[23:0] !== 24'h535251) begin n_fail++; $display("FAIL mid_partial got %h exp 535251", out[23:0]); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (out !== 256'd0) begin n_fail++; $display("FAIL mid_reset_out got %h exp 0", out); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got %b exp 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got %b exp 0", busy); end
    tick();
    reset = 1'b1;
    tick();
    start = 1'b1; length = 6'd0;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_len_busy got %b exp 0", busy); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_len_busy_after got %b exp 0", busy); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_idle_noise();
    test_gaps();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
